// File: rtl/clk_monitor_pkg.sv
// clk_monitor_pkg: shared definitions for the clock monitor.
//   state_t       - monitor FSM encoding
//   LOCK_PHASES   - consecutive in-tolerance phases needed to declare lock
//   PRIME_CYCLES  - cycles after reset before the edge detector is trusted
//   out_of_tol()  - unsigned, wrap-free |len - nom| > tol test
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SYNC      = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam int LOCK_PHASES  = 4;
  localparam int PRIME_CYCLES = 3;

  // Evaluated at 64 bits so neither the sum nor the comparison can wrap.
  function automatic logic out_of_tol(input logic [63:0] len,
                                      input logic [63:0] nom,
                                      input logic [63:0] tol);
    return (len > nom + tol) || (len + tol < nom);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (flops clear to 0)
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: measures high/low phase lengths of an asynchronous clock in
// units of clk cycles, flags out-of-tolerance phases and a stuck clock, and
// reports lock once the clock has been stable for LOCK_PHASES phases.
//   clk        - system clock, all logic on its rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - monitoring enable; low forces IDLE
//   mon_clk    - monitored clock (asynchronous)
//   high_len   - last measured high-phase length
//   low_len    - last measured low-phase length
//   meas_valid - one-cycle pulse when a full high+low period was measured
//   err_pulse  - one-cycle pulse on an errored phase or a stuck detection
//   err_count  - saturating count of err_pulse events
//   stuck      - monitored clock stopped; clears on its next edge
//   locked     - monitored clock stable within tolerance
// The FSM state is held in the internal signal "state" (state_t) for probing.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ERR_W    = 8,
  parameter int HALF_NOM = 4,
  parameter int TOL      = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_valid,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck,
  output logic             locked
);

  state_t           state;
  logic             sync2;
  logic             sync3;
  logic [1:0]       prime_cnt;
  logic             primed;
  logic             rise;
  logic             fall;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       good_cnt;
  logic             high_seen;
  logic             phase_done;
  logic             len_err;
  logic             timeout_evt;
  logic             err_evt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mon_clk),
    .q     (sync2)
  );

  // Right after reset the synchronizer flops start at 0; a high mon_clk
  // would then look like a rising edge that never happened. Edges are
  // ignored until the whole sync chain has been refilled.
  assign primed   = (prime_cnt == 2'(PRIME_CYCLES));
  assign rise     = primed &  sync2 & ~sync3;
  assign fall     = primed & ~sync2 &  sync3;
  assign edge_det = rise | fall;

  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // A phase is complete only when its terminating edge arrives while it is
  // being measured; the partial phase seen in SYNC is never checked.
  assign phase_done = enable && (((state == MEAS_HIGH) && fall) ||
                                 ((state == MEAS_LOW)  && rise));
  assign len_err    = out_of_tol(64'(cnt), 64'(HALF_NOM), 64'(TOL));

  // An edge in the same cycle wins over the timeout, and once stuck the
  // held counter must not fire again.
  assign timeout_evt = enable && (state != IDLE) && !edge_det && !stuck &&
                       (cnt == CNT_W'(TIMEOUT));
  assign err_evt     = (phase_done && len_err) || timeout_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync3      <= 1'b0;
      prime_cnt  <= '0;
      cnt        <= '0;
      high_len   <= '0;
      low_len    <= '0;
      meas_valid <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      stuck      <= 1'b0;
      locked     <= 1'b0;
      good_cnt   <= '0;
      high_seen  <= 1'b0;
    end else begin
      sync3      <= sync2;
      meas_valid <= 1'b0;
      err_pulse  <= 1'b0;
      if (!primed) prime_cnt <= prime_cnt + 2'd1;

      // State, counter and length registers.
      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        stuck     <= 1'b0;
        high_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= SYNC;
            cnt       <= '0;
            high_seen <= 1'b0;
          end
          SYNC: begin
            if (edge_det) begin
              stuck <= 1'b0;
              cnt   <= CNT_W'(1);
              state <= rise ? MEAS_HIGH : MEAS_LOW;
            end else if (timeout_evt) begin
              stuck <= 1'b1;
            end else if (!stuck) begin
              cnt <= cnt_inc;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              high_len  <= cnt;
              high_seen <= 1'b1;
              cnt       <= CNT_W'(1);
              state     <= MEAS_LOW;
            end else if (timeout_evt) begin
              stuck     <= 1'b1;
              high_seen <= 1'b0;
              state     <= SYNC;
            end else begin
              cnt <= cnt_inc;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              low_len    <= cnt;
              meas_valid <= high_seen;
              cnt        <= CNT_W'(1);
              state      <= MEAS_HIGH;
            end else if (timeout_evt) begin
              stuck     <= 1'b1;
              high_seen <= 1'b0;
              state     <= SYNC;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Error reporting and lock tracking.
      if (!enable) begin
        locked   <= 1'b0;
        good_cnt <= '0;
      end else if (err_evt) begin
        err_pulse <= 1'b1;
        locked    <= 1'b0;
        good_cnt  <= '0;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end else if (phase_done) begin
        if (good_cnt >= 3'(LOCK_PHASES - 1)) begin
          locked   <= 1'b1;
          good_cnt <= 3'(LOCK_PHASES);
        end else begin
          good_cnt <= good_cnt + 3'd1;
        end
      end
    end
  end

endmodule
